seq_muldiv: RTL
===============

SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_valid  input  1  request valid.
REQ-005 o_ready  output  1  block idle, request accepted when i_valid && o_ready.
REQ-006 i_op  input  1  0 = MUL unsigned 32x32->64, 1 = DIV unsigned.
REQ-007 i_a  input  32  multiplicand / dividend.
REQ-008 i_b  input  32  multiplier / divisor.
REQ-009 o_valid  output  1  result valid, held until i_ready.
REQ-010 i_ready  input  1  consumer accepts result when o_valid && i_ready.
REQ-011 o_hi  output  32  MUL product[63:32]; DIV remainder.
REQ-012 o_lo  output  32  MUL product[31:0]; DIV quotient.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; o_ready = (state == IDLE).
REQ-015 IDLE: on accept, latch i_op, i_a, i_b; load counter 0; go to CALC; other inputs ignored.
REQ-016 CALC SHALL run exactly 32 iterations, one per cycle, counter 0..31; after iteration 31 go to DONE.
REQ-017 Latency: accept in cycle N -> o_valid first high in cycle N+33.
REQ-018 MUL iteration: if lo[0]=1 add b to hi via shared adder (Sel=0), else add 0; shift {Cout, sum, lo} right by 1.
REQ-019 DIV iteration: shift {rem, quo} left 1; trial = rem_shifted - b via shared adder (Sel=1); if bit shifted out of rem was 1 or Cout=1, rem = trial and quo[0]=1, else rem unchanged and quo[0]=0.
REQ-020 DIV with i_b = 0 SHALL skip CALC: go to DONE next cycle, o_valid at N+1, o_lo = 0xFFFFFFFF, o_hi = i_a.
REQ-021 DONE: o_valid=1, o_hi/o_lo stable until i_ready; on handshake go to IDLE next cycle; earliest next accept is the cycle after the handshake.
REQ-022 i_valid in CALC or DONE SHALL be ignored, no queuing.
REQ-023 i_ready while o_valid=0 SHALL have no effect.
REQ-024 All arithmetic unsigned, modulo 2^32 per word; no overflow flag.

Reset
REQ-025 i_reset SHALL force state IDLE, counter 0, o_valid=0, o_hi=0, o_lo=0, o_busy=0, o_ready=1 on the next clock edge.
REQ-026 Reset in CALC or DONE SHALL abort the operation; the result is discarded and no o_valid is produced.

Configuration
REQ-027 Macro SEQ_MULDIV_DIV_EN defined: DIV fully supported per REQ-019/020.
REQ-028 SEQ_MULDIV_DIV_EN undefined: no divide datapath or muxing synthesized; i_op=1 accepted, DONE at N+1 with o_hi=o_lo=0; MUL unchanged.

Structure
REQ-029 Package seq_muldiv_pkg SHALL hold XLEN=32, CNT_W=6, state enum (IDLE, CALC, DONE), op enum (OP_MUL, OP_DIV).
REQ-030 Exactly one add_sub_32_bit instance SHALL serve as the sole adder/subtractor for both operations; no other adders except the counter increment.

Verification
REQ-031 MUL 0xFFFFFFFF x 0xFFFFFFFF, accept cycle N -> o_valid at N+33, o_hi=0xFFFFFFFE, o_lo=0x00000001.
REQ-032 DIV 100 / 7 -> o_lo=14, o_hi=2 at N+33; DIV 0xFFFFFFFF / 0x80000000 -> o_lo=1, o_hi=0x7FFFFFFF.
REQ-033 DIV 0x12345678 / 0 -> o_valid at N+1, o_lo=0xFFFFFFFF, o_hi=0x12345678.
REQ-034 MUL 3 x 5 with i_ready low 5 cycles after o_valid, i_valid pulsed meanwhile -> o_lo=15, o_hi=0 held stable, o_ready=0, no second accept; IDLE the cycle after i_ready.
REQ-035 i_reset asserted at CALC iteration 10 -> next cycle o_ready=1, o_busy=0, o_valid=0, outputs 0; no result delivered.
REQ-036 Build without SEQ_MULDIV_DIV_EN: DIV 100 / 7 -> o_valid at N+1, o_hi=o_lo=0; MUL 6 x 7 -> o_lo=42 at N+33.

Source files
------------

// File: rtl/seq_muldiv_pkg.sv
// Shared types and widths for the sequential multiply/divide unit.
package seq_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage

// File: rtl/seq_muldiv_add_sub.sv
// Shared 32-bit adder/subtractor; i_sel=1 computes i_a - i_b, where o_cout=1 means no borrow.
module add_sub_32_bit
    import seq_muldiv_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_sel,
    output logic [XLEN-1:0] o_sum,
    output logic            o_cout
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   result;

    assign b_eff  = i_sel ? ~i_b : i_b;
    assign result = {1'b0, i_a} + {1'b0, b_eff} + (XLEN+1)'(i_sel);
    assign o_sum  = result[XLEN-1:0];
    assign o_cout = result[XLEN];

endmodule

// File: rtl/seq_muldiv.sv
// Radix-2 sequential unsigned 32x32 multiplier and divider sharing one adder/subtractor.
// Divide support is compiled in only when SEQ_MULDIV_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// CALC  | 32 shift/add (MUL) or shift/subtract (DIV) iterations
// DONE  | result presented on o_hi/o_lo until the consumer takes it
module seq_muldiv
    import seq_muldiv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             valid_q, ready_q, busy_q;
`ifdef SEQ_MULDIV_DIV_EN
    op_e              op_q, op_d;
`endif

    logic [XLEN-1:0]  add_a, add_b, add_sum;
    logic             add_sel, add_cout;

    add_sub_32_bit u_add_sub (
        .i_a    (add_a),
        .i_b    (add_b),
        .i_sel  (add_sel),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // hi holds the partial product (MUL) or partial remainder (DIV)
    always_comb begin
        add_a   = hi_q;
        add_b   = lo_q[0] ? b_q : '0;
        add_sel = 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
        if (op_q == OP_DIV) begin
            add_a   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            add_b   = b_q;
            add_sel = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
`ifdef SEQ_MULDIV_DIV_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    cnt_d   = '0;
                    b_d     = i_b;
                    hi_d    = '0;
                    lo_d    = i_a;
                    state_d = CALC;
`ifdef SEQ_MULDIV_DIV_EN
                    op_d = op_e'(i_op);
                    if (i_op == OP_DIV && i_b == '0) begin
                        hi_d    = i_a;
                        lo_d    = '1;
                        state_d = DONE;
                    end
`else
                    if (i_op == OP_DIV) begin
                        lo_d    = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_MULDIV_DIV_EN
                if (op_q == OP_DIV) begin
                    // a set bit shifted out of rem means rem_shifted >= 2^32 > b
                    if (hi_q[XLEN-1] || add_cout) begin
                        hi_d = add_sum;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {hi_d, lo_d} = {add_cout, add_sum, lo_q[XLEN-1:1]};
                end
`else
                {hi_d, lo_d} = {add_cout, add_sum, lo_q[XLEN-1:1]};
`endif
                if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
            op_q    <= OP_MUL;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            valid_q <= (state_d == DONE);
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
`ifdef SEQ_MULDIV_DIV_EN
            op_q    <= op_d;
`endif
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule
